// File: rtl/weight_ram_loader_if.sv
// Stream-in / RAM-write port bundle for weight_ram_loader.
// master = upstream stream source and RAM observer, slave = the loader itself.
interface weight_ram_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_WORDS  = 288
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_W-1:0]     wr_addr;
  logic [NUM_WORDS-1:0]  wr_en;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_data, wr_addr, wr_en
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_data, wr_addr, wr_en
  );
endinterface

// File: rtl/weight_ram_loader.sv
// Byte-serial stream to wide block-RAM loader: scatters each accepted word into
// the next slot of the current row, rows ascending, then flags the RAM as valid.
module weight_ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_WORDS  = 288
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  weight_ram_loader_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               ram_valid
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, LAST} state_t;

  state_t               state;
  logic [NUM_WORDS-1:0] word_oh;
  logic [ADDR_W-1:0]    row;
  logic                 hs;

  assign hs = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_oh      <= '0;
      row          <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_data  <= {DATA_WIDTH{1'b0}};
      bus.wr_addr  <= '0;
      bus.wr_en    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_valid    <= 1'b0;
    end else begin
      bus.wr_en <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            word_oh      <= NUM_WORDS'(1);
            row          <= '0;
            ram_valid    <= 1'b0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            bus.wr_data <= bus.in_data;
            bus.wr_addr <= row;
            bus.wr_en   <= word_oh;
            // Rotating the one-hot slot pointer wraps the final slot back to slot 0.
            word_oh     <= {word_oh[NUM_WORDS-2:0], word_oh[NUM_WORDS-1]};
            if (word_oh[NUM_WORDS-1]) begin
              if (row == LAST_ROW) begin
                state        <= LAST;
                bus.in_ready <= 1'b0;
              end else begin
                row <= row + ADDR_W'(1);
              end
            end
          end
        end
        LAST: begin
          // The final write is on the RAM port this cycle; completion is flagged after it commits.
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          ram_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
